nmi_arbiter: RTL

- Schedules the single Z80 NMI line between up to four requesters: magic button, pause button, divMMC button and an external/PS2 hotkey.
- Latches request edges, chooses one winner per frame and asserts n_nmi aligned to the INT boundary.
- Releases n_nmi on the CPU's M1 fetch at 0x0066.
- Exposes cause, pending status and an end-of-service handshake through a magic-mapped I/O port.

---
 rtl/nmi_arbiter_pkg.sv | 29 ++
 rtl/nmi_arbiter_if.sv | 13 +
 rtl/nmi_arbiter_prio_enc.sv | 19 +
 rtl/nmi_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/nmi_arbiter_pkg.sv
// Shared types and constants for the NMI arbiter: FSM states, NMI cause codes,
// port address constants and the status-byte packing helper.
package nmi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_INT = 2'd1,
    ASSERT   = 2'd2,
    SERVICE  = 2'd3
  } nmi_state_t;

  typedef enum logic [1:0] {
    NMI_CAUSE_MAGIC  = 2'd0,
    NMI_CAUSE_PAUSE  = 2'd1,
    NMI_CAUSE_DIVMMC = 2'd2,
    NMI_CAUSE_EXT    = 2'd3
  } nmi_cause_t;

  localparam logic [7:0]  NMI_PORT_HI = 8'h0C;
  localparam logic [7:0]  NMI_PORT_LO = 8'hFF;
  localparam logic [15:0] NMI_VECTOR  = 16'h0066;

  // Status byte: {cause, in-service, 0, pending[3:0]}
  function automatic logic [7:0] nmi_status(input nmi_cause_t c, input logic act,
                                            input logic [3:0] pend);
    return {c, act, 1'b0, pend};
  endfunction

endpackage

// File: rtl/nmi_arbiter_if.sv
// Z80 CPU bus as seen by the NMI arbiter; the CPU side drives, the arbiter listens.
interface cpu_bus;
  logic        memreq;
  logic        ioreq;
  logic        rd;
  logic        wr;
  logic        m1;
  logic [15:0] a_reg;
  logic [7:0]  d_reg;

  modport master (output memreq, ioreq, rd, wr, m1, a_reg, d_reg);
  modport slave  (input  memreq, ioreq, rd, wr, m1, a_reg, d_reg);
endinterface

// File: rtl/nmi_arbiter_prio_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module nmi_prio_enc #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] bits,
  output logic [1:0]      idx,
  output logic            any
);

  always_comb begin
    idx = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (bits[i]) idx = i[1:0];
    end
  end

  assign any = |bits;

endmodule

// File: rtl/nmi_arbiter.sv
// Schedules the single Z80 NMI line between up to four edge-triggered requesters,
// issues it on the INT boundary and releases it on the M1 fetch of the NMI vector.
module nmi_arbiter
  import nmi_arbiter_pkg::*;
#(
  parameter int         NSRC    = 4,
  parameter int         TIMEOUT = 1120000,
  parameter logic [7:0] PORT_HI = NMI_PORT_HI
) (
  input  logic            rst_n,
  input  logic            clk28,
  cpu_bus.slave           bus,
  input  logic [NSRC-1:0] req,
  input  logic            n_int,
  input  logic            n_int_next,
  input  logic            inhibit,
  input  logic            magic_map,
  output logic            n_nmi,
  output logic            nmi_active,
  output logic [1:0]      cause,
  output logic [7:0]      d_out,
  output logic            d_out_active
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

  nmi_state_t      state_reg;
  nmi_cause_t      cause_reg;
  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] req_d_reg;
  logic [TW-1:0]   timer_reg;
  logic            n_nmi_reg;
  logic            nmi_active_reg;
  logic [7:0]      d_out_reg;
  logic            d_out_active_reg;

  logic            cs;
  logic            port_rd;
  logic            end_service;
  logic            clear_all;
  logic            boundary;
  logic            vector_fetch;
  logic [1:0]      win_idx;
  logic            win_any;
  logic            grant;
  logic            time_out;
  logic [NSRC-1:0] req_edge;
  logic [NSRC-1:0] win_mask;
  logic [NSRC-1:0] cause_mask;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] pend_set;
  logic [NSRC-1:0] pending_next;
  logic [3:0]      pending4;
  logic [7:0]      status;
  wire             unused_d = ^bus.d_reg[6:1];

  assign cs           = magic_map && bus.ioreq && (bus.a_reg == {PORT_HI, NMI_PORT_LO});
  assign port_rd      = cs && bus.rd;
  assign end_service  = cs && bus.wr && bus.d_reg[0];
  assign clear_all    = cs && bus.wr && bus.d_reg[7];
  assign boundary     = n_int && !n_int_next;
  assign vector_fetch = bus.m1 && bus.memreq && (bus.a_reg == NMI_VECTOR);

  nmi_prio_enc #(.NSRC(NSRC)) u_prio (
    .bits (pending_reg),
    .idx  (win_idx),
    .any  (win_any)
  );

  assign grant      = (state_reg == WAIT_INT) && win_any && boundary && !inhibit;
  assign time_out   = (state_reg == ASSERT) && !vector_fetch && (timer_reg == TIMER_LAST);
  assign req_edge   = req & ~req_d_reg;
  assign win_mask   = NSRC'(1) << win_idx;
  assign cause_mask = NSRC'(1) << cause_reg;

  // Sets are applied after clears so a coincident new edge is never lost.
  assign pend_clr     = (clear_all ? {NSRC{1'b1}} : {NSRC{1'b0}}) | (grant ? win_mask : {NSRC{1'b0}});
  assign pend_set     = req_edge | (time_out ? cause_mask : {NSRC{1'b0}});
  assign pending_next = (pending_reg & ~pend_clr) | pend_set;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      if (gi < NSRC) begin : g_src
        assign pending4[gi] = pending_reg[gi];
      end else begin : g_none
        assign pending4[gi] = 1'b0;
      end
    end
  endgenerate

  assign status = nmi_status(cause_reg, nmi_active_reg, pending4);

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cause_reg        <= NMI_CAUSE_MAGIC;
      pending_reg      <= '0;
      req_d_reg        <= '0;
      timer_reg        <= '0;
      n_nmi_reg        <= 1'b1;
      nmi_active_reg   <= 1'b0;
      d_out_reg        <= 8'h00;
      d_out_active_reg <= 1'b0;
    end else begin
      req_d_reg        <= req;
      pending_reg      <= pending_next;
      d_out_active_reg <= port_rd;
      d_out_reg        <= port_rd ? status : 8'h00;

      case (state_reg)
        IDLE: begin
          if (win_any && !inhibit) state_reg <= WAIT_INT;
        end
        WAIT_INT: begin
          if (!win_any) begin
            state_reg <= IDLE;
          end else if (boundary && !inhibit) begin
            cause_reg <= nmi_cause_t'(win_idx);
            n_nmi_reg <= 1'b0;
            timer_reg <= '0;
            state_reg <= ASSERT;
          end
        end
        ASSERT: begin
          if (timer_reg != TIMER_MAX) timer_reg <= timer_reg + TW'(1);
          if (vector_fetch) begin
            n_nmi_reg      <= 1'b1;
            nmi_active_reg <= 1'b1;
            state_reg      <= SERVICE;
          end else if (timer_reg == TIMER_LAST) begin
            n_nmi_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        SERVICE: begin
          if (end_service) begin
            nmi_active_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign n_nmi        = n_nmi_reg;
  assign nmi_active   = nmi_active_reg;
  assign cause        = cause_reg;
  assign d_out        = d_out_reg;
  assign d_out_active = d_out_active_reg;

endmodule
